// File: rtl/bist_pkg.sv
// bist_pkg: FSM state type and default widths shared by the BIST signature controller.
package bist_pkg;
  localparam int BIST_NUM_BITS = 54;
  localparam int BIST_CNT_W = 16;
  localparam int BIST_TIMEOUT_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, CHECK, DONE} state_t;
endpackage

// File: rtl/bist_sig_ctrl.sv
// bist_sig_ctrl: seeds a MISR, streams N array result beats into it and checks the captured signature.
// Defining BIST_TIMEOUT_EN adds a RUN stall watchdog that ends the test with o_timeout set.
module bist_sig_ctrl
  import bist_pkg::*;
#(
  parameter int NUM_BITS = BIST_NUM_BITS,
  parameter int CNT_W = BIST_CNT_W
`ifdef BIST_TIMEOUT_EN
  , parameter int TIMEOUT_W = BIST_TIMEOUT_W
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [CNT_W-1:0]    i_num_beats,
  input  logic [NUM_BITS-1:0] i_seed,
  input  logic [NUM_BITS-1:0] i_golden,
  input  logic                i_dut_vld,
  input  logic [NUM_BITS-1:0] i_dut_data,
  input  logic                i_misr_vld,
  input  logic [NUM_BITS-1:0] i_misr_data,
  output logic                o_misr_en,
  output logic                o_misr_load,
  output logic [NUM_BITS-1:0] o_misr_din,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [NUM_BITS-1:0] o_signature,
  output logic                o_timeout
);
  state_t r_state;
  logic [CNT_W-1:0] r_num, r_cnt;
  logic [NUM_BITS-1:0] r_seed, r_golden, r_sig;
  logic r_pass, r_timeout, r_drain_ok;
  logic w_load, w_run;
`ifdef BIST_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_stall, w_stall_nxt;
  assign w_stall_nxt = r_stall + TIMEOUT_W'(1);
`endif
  assign w_load = r_state == LOAD;
  assign w_run = r_state == RUN;
  assign o_misr_en = w_load | (w_run & i_dut_vld);
  assign o_misr_load = w_load;
  assign o_misr_din = w_load ? r_seed : w_run ? i_dut_data : '0;
  assign o_busy = r_state inside {LOAD, RUN, DRAIN, CHECK};
  assign o_done = r_state == DONE;
  assign o_pass = r_pass;
  assign o_signature = r_sig;
  assign o_timeout = r_timeout;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state <= IDLE;
      r_num <= '0;
      r_cnt <= '0;
      r_seed <= '0;
      r_golden <= '0;
      r_sig <= '0;
      r_pass <= 1'b0;
      r_timeout <= 1'b0;
      r_drain_ok <= 1'b0;
`ifdef BIST_TIMEOUT_EN
      r_stall <= '0;
`endif
    end else if (i_abort) begin
      r_state <= IDLE;
      r_pass <= 1'b0;
      r_timeout <= 1'b0;
    end else
      case (r_state)
        IDLE, DONE:
          if (i_start) begin
            r_state <= LOAD;
            r_num <= i_num_beats;
            r_seed <= i_seed;
            r_golden <= i_golden;
            r_cnt <= '0;
            r_sig <= '0;
            r_pass <= 1'b0;
            r_timeout <= 1'b0;
`ifdef BIST_TIMEOUT_EN
            r_stall <= '0;
`endif
          end
        LOAD: r_state <= r_num == '0 ? DRAIN : RUN;
        RUN:
          if (i_dut_vld) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == r_num - CNT_W'(1)) r_state <= DRAIN;
`ifdef BIST_TIMEOUT_EN
            r_stall <= '0;
          end else if (&w_stall_nxt) begin
            r_state <= DONE;
            r_timeout <= 1'b1;
            r_pass <= 1'b0;
            r_sig <= '0;
          end else r_stall <= w_stall_nxt;
`else
          end
`endif
        // the MISR output is only trustworthy if the last cycle before DRAIN clocked it
        DRAIN: begin
          r_sig <= i_misr_data;
          r_drain_ok <= i_misr_vld;
          r_state <= CHECK;
        end
        CHECK: begin
          r_pass <= (r_sig == r_golden) & r_drain_ok;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
endmodule
